// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the CPU instruction/data memory arbiter.
//   - FSM state encoding, owner encoding, latched memory command payload
//   - default starvation limit for the instruction port
package cpu_mem_arbiter_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned STRB_W           = 4;
    localparam int unsigned STARVE_W         = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    // Request fields presented on the shared memory port
    typedef struct packed {
        logic              wr;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates a CPU fetch port and a load/store port onto one shared memory
// port with at most one outstanding transaction. Data wins by default; the
// fetch port wins once data has been granted STARVE_LIMIT times in a row
// while a fetch was waiting (STARVE_LIMIT must be 1..15).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   inst_req/addr               fetch request in
//   inst_addr_ok/data_ok/rdata  fetch handshake out
//   data_req/wr/wstrb/addr/wdata load/store request in
//   data_addr_ok/data_ok/rdata  load/store handshake out
//   mem_req/wr/wstrb/addr/wdata shared memory request out
//   mem_addr_ok/data_ok/rdata   shared memory handshake in
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    owner_e              r_owner;
    owner_e              w_winner;
    mem_cmd_t            r_cmd;
    mem_cmd_t            w_inst_cmd;
    mem_cmd_t            w_data_cmd;
    mem_cmd_t            w_win_cmd;
    mem_cmd_t            w_mem_cmd;
    logic [STARVE_W-1:0] r_starve;
    logic                w_starved;
    logic                w_grant;

    // Candidate commands and the IDLE-state winner
    always_comb begin
        w_inst_cmd       = '0;
        w_inst_cmd.addr  = inst_addr;

        w_data_cmd.wr    = data_wr;
        w_data_cmd.wstrb = data_wr ? data_wstrb : '0;
        w_data_cmd.addr  = data_addr;
        w_data_cmd.wdata = data_wdata;

        w_starved = inst_req && data_req &&
                    (r_starve == STARVE_W'(STARVE_LIMIT));
        w_grant   = !reset && (r_state == ST_IDLE) && (inst_req || data_req);
        w_winner  = (data_req && !w_starved) ? OWNER_DATA : OWNER_INST;
        w_win_cmd = (w_winner == OWNER_DATA) ? w_data_cmd : w_inst_cmd;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = mem_addr_ok ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (mem_addr_ok) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's fields so ADDR ignores requester changes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd   <= '0;
            r_owner <= OWNER_INST;
        end else if (w_grant) begin
            r_cmd   <= w_win_cmd;
            r_owner <= w_winner;
        end
    end

    // Consecutive data grants while a fetch waits; saturates at all-ones
    always_ff @(posedge clk) begin
        if (reset || !inst_req) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (w_winner == OWNER_INST) begin
                r_starve <= '0;
            end else if (r_starve != {STARVE_W{1'b1}}) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
        end
    end

    // Outputs; everything held at zero while reset is high
    always_comb begin
        w_mem_cmd    = '0;
        mem_req      = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        if (!reset) begin
            inst_rdata = mem_rdata;
            data_rdata = mem_rdata;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        mem_req      = 1'b1;
                        w_mem_cmd    = w_win_cmd;
                        inst_addr_ok = mem_addr_ok && (w_winner == OWNER_INST);
                        data_addr_ok = mem_addr_ok && (w_winner == OWNER_DATA);
                    end
                end
                ST_ADDR: begin
                    mem_req      = 1'b1;
                    w_mem_cmd    = r_cmd;
                    inst_addr_ok = mem_addr_ok && (r_owner == OWNER_INST);
                    data_addr_ok = mem_addr_ok && (r_owner == OWNER_DATA);
                end
                ST_DATA: begin
                    inst_data_ok = mem_data_ok && (r_owner == OWNER_INST);
                    data_data_ok = mem_data_ok && (r_owner == OWNER_DATA);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_wr    = w_mem_cmd.wr;
    assign mem_wstrb = w_mem_cmd.wstrb;
    assign mem_addr  = w_mem_cmd.addr;
    assign mem_wdata = w_mem_cmd.wdata;

endmodule
